// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// LfsrChecker (top module lfsr_checker)
//
// Receive-side partner of a Fibonacci LFSR next-state generator. Watches a
// stream of LFSR words, synchronises to it, then predicts every following
// word. While locked, each wrong word raises a one-cycle err_pulse and bumps
// a saturating error counter. Repeated misses drop lock and the checker
// hunts for the sequence again.
//
// Next-state rule: fb = ^(word & TAPS), next(word) = {word[WIDTH-2:0], fb}.
//
// Parameters:
//   WIDTH    LFSR word width
//   TAPS     feedback tap mask
//   SYNC_LEN consecutive correct predictions needed to lock (1..15)
//   LOSS_LEN consecutive misses while locked that drop lock (1..15)
//   CNT_W    error counter width
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   in_data is sampled this cycle
//   in_data    in   received LFSR word
//   clear      in   synchronous clear of err_count (and zero_seen)
//   locked     out  checker synchronised
//   err_pulse  out  one-cycle mismatch strobe, only while locked
//   err_count  out  saturating mismatch count
//   zero_seen  out  sticky all-zero detect (optional feature, else 0)
//
// Optional feature macro: LFSR_CHK_ZERO_DETECT_EN
//   When defined, an all-zero word in VERIFY or LOCKED forces an immediate
//   return to HUNT, sets zero_seen, and counts as an error when locked.
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
  parameter int               SYNC_LEN = 3,
  parameter int               LOSS_LEN = 3,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             zero_seen
);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_LEN);

  function automatic logic [WIDTH-1:0] lfsrNext(input logic [WIDTH-1:0] word);
    return {word[WIDTH-2:0], ^(word & TAPS)};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_expected;
  logic [3:0]       r_good_cnt;
  logic [3:0]       r_bad_cnt;
  logic             r_locked;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_count;

  logic [WIDTH-1:0] w_next_data;
  logic [WIDTH-1:0] w_next_exp;
  logic             w_match;
  logic             w_zero;
  logic             w_count_err;
  logic             w_err_sat;

  assign w_next_data = lfsrNext(in_data);
  assign w_next_exp  = lfsrNext(r_expected);
  assign w_match     = (in_data == r_expected);
  assign w_zero      = (in_data == '0);
  assign w_err_sat   = &r_err_count;

  // An error is counted only while locked. With zero detect enabled the
  // all-zero word is always an error there, even if it happened to match.
`ifdef LFSR_CHK_ZERO_DETECT_EN
  assign w_count_err = in_valid && (r_state == LOCKED) && (!w_match || w_zero);
`else
  assign w_count_err = in_valid && (r_state == LOCKED) && !w_match;
`endif

  // Main sequencer: hunt for a non-zero seed, verify SYNC_LEN predictions,
  // then flywheel on the internal prediction while locked. The locked flag
  // is registered alongside the state so it follows the sampled word by one
  // clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= HUNT;
      r_expected <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_locked   <= 1'b0;
    end else if (in_valid) begin
      case (r_state)
        HUNT: begin
          // The all-zero word is the LFSR lock-up state and cannot seed.
          if (!w_zero) begin
            r_expected <= w_next_data;
            r_good_cnt <= '0;
            r_state    <= VERIFY;
          end
        end

        VERIFY: begin
          if (w_match) begin
            r_expected <= w_next_data;
            if ((r_good_cnt + 4'd1) == SYNC_LAST) begin
              r_good_cnt <= '0;
              r_bad_cnt  <= '0;
              r_locked   <= 1'b1;
              r_state    <= LOCKED;
            end else begin
              r_good_cnt <= r_good_cnt + 4'd1;
            end
          end else if (!w_zero) begin
            r_expected <= w_next_data;
            r_good_cnt <= '0;
          end else begin
            r_good_cnt <= '0;
            r_state    <= HUNT;
          end
        end

        LOCKED: begin
          // Never reseed from data here; a corrupted word must not pull the
          // prediction off the true sequence.
          r_expected <= w_next_exp;
`ifdef LFSR_CHK_ZERO_DETECT_EN
          if (w_zero) begin
            r_bad_cnt <= '0;
            r_locked  <= 1'b0;
            r_state   <= HUNT;
          end else
`endif
          if (w_match) begin
            r_bad_cnt <= '0;
          end else if ((r_bad_cnt + 4'd1) == LOSS_LAST) begin
            r_bad_cnt <= '0;
            r_locked  <= 1'b0;
            r_state   <= HUNT;
          end else begin
            r_bad_cnt <= r_bad_cnt + 4'd1;
          end
        end

        default: begin
          r_locked <= 1'b0;
          r_state  <= HUNT;
        end
      endcase
    end
  end

  // Error reporting: the pulse always follows a counted error, while clear
  // takes priority over the increment so a coincident error is dropped from
  // the count but still strobed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_count_err;
      if (clear) begin
        r_err_count <= '0;
      end else if (w_count_err && !w_err_sat) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

`ifdef LFSR_CHK_ZERO_DETECT_EN
  logic r_zero_seen;

  // Sticky record of an all-zero word arriving outside HUNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero_seen <= 1'b0;
    end else if (clear) begin
      r_zero_seen <= 1'b0;
    end else if (in_valid && w_zero && (r_state != HUNT)) begin
      r_zero_seen <= 1'b1;
    end
  end

  assign zero_seen = r_zero_seen;
`else
  assign zero_seen = 1'b0;
`endif

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// Testbench for lfsr_checker. Two instances: A with the default 16-bit error
// counter carries the main stream; B with a 2-bit counter exercises
// saturation. Expected outputs are queued when a word is driven and popped
// after the following rising edge.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

`ifdef LFSR_CHK_ZERO_DETECT_EN
  localparam int LOSS_ERR = 1;
  localparam int TBL_CHKZ = 0;
`else
  localparam int LOSS_ERR = 3;
  localparam int TBL_CHKZ = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aValid, aClear, aLocked, aPulse, aZero;
  logic [3:0]  aData;
  logic [15:0] aCount;
  logic        bValid, bClear, bLocked, bPulse, bZero;
  logic [3:0]  bData;
  logic [1:0]  bCount;

  typedef struct {
    string       tag;
    bit          dutB;
    logic        v;
    logic [3:0]  d;
    logic        c;
    logic        l;
    logic        p;
    logic [15:0] cnt;
    logic        z;
    bit          chkZ;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   stepNo     = 0;

  always #5 clk = ~clk;

  lfsr_checker dutA (
    .clk(clk), .reset_n(reset_n), .in_valid(aValid), .in_data(aData),
    .clear(aClear), .locked(aLocked), .err_pulse(aPulse),
    .err_count(aCount), .zero_seen(aZero)
  );

  lfsr_checker #(.CNT_W(2)) dutB (
    .clk(clk), .reset_n(reset_n), .in_valid(bValid), .in_data(bData),
    .clear(bClear), .locked(bLocked), .err_pulse(bPulse),
    .err_count(bCount), .zero_seen(bZero)
  );

  function automatic vec_t mk(string tag, int b, int v, logic [3:0] d, int c,
                              int l, int p, int cnt, int z, int chkZ);
    vec_t r;
    r.tag  = tag;
    r.dutB = 1'(b);
    r.v    = 1'(v);
    r.d    = d;
    r.c    = 1'(c);
    r.l    = 1'(l);
    r.p    = 1'(p);
    r.cnt  = 16'(cnt);
    r.z    = 1'(z);
    r.chkZ = 1'(chkZ);
    return r;
  endfunction

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, stepNo, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty (step %0d): got 0 entries, expected 1", stepNo);
      return;
    end
    e = sb.pop_front();
    if (e.dutB) begin
      cmp({e.tag, "_locked"}, 16'(bLocked), 16'(e.l));
      cmp({e.tag, "_pulse"},  16'(bPulse),  16'(e.p));
      cmp({e.tag, "_count"},  16'(bCount),  16'(e.cnt[1:0]));
    end else begin
      cmp({e.tag, "_locked"}, 16'(aLocked), 16'(e.l));
      cmp({e.tag, "_pulse"},  16'(aPulse),  16'(e.p));
      cmp({e.tag, "_count"},  aCount,       e.cnt);
      if (e.chkZ) cmp({e.tag, "_zero"}, 16'(aZero), 16'(e.z));
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    stepNo++;
    aValid = 1'b0; aData = 4'b0000; aClear = 1'b0;
    bValid = 1'b0; bData = 4'b0000; bClear = 1'b0;
    if (v.dutB) begin
      bValid = v.v; bData = v.d; bClear = v.c;
    end else begin
      aValid = v.v; aData = v.d; aClear = v.c;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    aValid = 1'b0; aData = 4'b0000; aClear = 1'b0;
    bValid = 1'b0; bData = 4'b0000; bClear = 1'b0;
  endtask

  initial begin
    logic [3:0] trk[12] = '{4'b1110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0110,
                            4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rel[4]  = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};
    logic [3:0] vfy[10] = '{4'b0101, 4'b1011, 4'b0000, 4'b0110, 4'b1100,
                            4'b1001, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    int E;
    E = LOSS_ERR;

    // Lock acquisition on the maximal-length sequence.
    tbl.push_back(mk("lock", 0, 1, 4'b0001, 0, 0, 0, 0, 0, TBL_CHKZ));
    tbl.push_back(mk("lock", 0, 1, 4'b0011, 0, 0, 0, 0, 0, TBL_CHKZ));
    tbl.push_back(mk("lock", 0, 1, 4'b0111, 0, 0, 0, 0, 0, TBL_CHKZ));
    tbl.push_back(mk("lock", 0, 1, 4'b1111, 0, 1, 0, 0, 0, TBL_CHKZ));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk("track", 0, 1, trk[i], 0, 1, 0, 0, 0, TBL_CHKZ));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("track", 0, 1, rel[i], 0, 1, 0, 0, 0, TBL_CHKZ));
    // Single error: expected 1101, send 1111, then resume.
    tbl.push_back(mk("single", 0, 1, 4'b1111, 0, 1, 1, 1, 0, TBL_CHKZ));
    tbl.push_back(mk("single", 0, 1, 4'b1010, 0, 1, 0, 1, 0, TBL_CHKZ));
    tbl.push_back(mk("single", 0, 1, 4'b0101, 0, 1, 0, 1, 0, TBL_CHKZ));
    // Five idle cycles mid-stream hold everything.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("gap", 0, 0, 4'b0000, 0, 1, 0, 1, 0, TBL_CHKZ));
    tbl.push_back(mk("gap", 0, 1, 4'b1011, 0, 1, 0, 1, 0, TBL_CHKZ));
    // Clear coincident with a mismatch: count zeroed, pulse still fires.
    tbl.push_back(mk("clrerr", 0, 1, 4'b0001, 1, 1, 1, 0, 0, TBL_CHKZ));
    tbl.push_back(mk("clrerr", 0, 1, 4'b1100, 0, 1, 0, 0, 0, TBL_CHKZ));
    // Loss of lock via zero words.
`ifdef LFSR_CHK_ZERO_DETECT_EN
    tbl.push_back(mk("loss", 0, 1, 4'b0000, 0, 0, 1, 1, 1, TBL_CHKZ));
`else
    tbl.push_back(mk("loss", 0, 1, 4'b0000, 0, 1, 1, 1, 0, TBL_CHKZ));
    tbl.push_back(mk("loss", 0, 1, 4'b0000, 0, 1, 1, 2, 0, TBL_CHKZ));
    tbl.push_back(mk("loss", 0, 1, 4'b1000, 0, 0, 1, 3, 0, TBL_CHKZ));
`endif
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("relock", 0, 1, rel[i], 0, (i == 3) ? 1 : 0, 0, E, 0, TBL_CHKZ));
    // Drop lock again with non-zero misses.
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mk("loss2", 0, 1, 4'b0001, 0, (i == 3) ? 0 : 1, 1, E + i, 0, TBL_CHKZ));
    // Zero ignored in HUNT; zero in VERIFY re-hunts; reseed restarts count.
    tbl.push_back(mk("huntzero", 0, 1, 4'b0000, 0, 0, 0, E + 3, 0, TBL_CHKZ));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk("verify", 0, 1, vfy[i], 0, (i == 9) ? 1 : 0, 0, E + 3, 0, TBL_CHKZ));

    reset_n = 1'b0;
    idleInputs();
    #12;
    cmp("reset_locked", 16'(aLocked), 16'(0));
    cmp("reset_pulse",  16'(aPulse),  16'(0));
    cmp("reset_count",  aCount,       16'(0));
    cmp("reset_zero",   16'(aZero),   16'(0));
    cmp("reset_countB", 16'(bCount),  16'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i]);

    // Lose lock, then reset asynchronously after two VERIFY matches.
    for (int i = 1; i <= 3; i++)
      applyStimulus(mk("loss3", 0, 1, 4'b0001, 0, (i == 3) ? 0 : 1, 1, E + 3 + i, 0, TBL_CHKZ));
    applyStimulus(mk("prerst", 0, 1, 4'b0001, 0, 0, 0, E + 6, 0, TBL_CHKZ));
    applyStimulus(mk("prerst", 0, 1, 4'b0011, 0, 0, 0, E + 6, 0, TBL_CHKZ));
    applyStimulus(mk("prerst", 0, 1, 4'b0111, 0, 0, 0, E + 6, 0, TBL_CHKZ));
    #2;
    reset_n = 1'b0;
    idleInputs();
    #1;
    cmp("midrst_locked", 16'(aLocked), 16'(0));
    cmp("midrst_pulse",  16'(aPulse),  16'(0));
    cmp("midrst_count",  aCount,       16'(0));
    cmp("midrst_zero",   16'(aZero),   16'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(mk("postrst", 0, 1, rel[i], 0, (i == 3) ? 1 : 0, 0, 0, 0, 1));

    // All-zero word while locked (expected 1101).
`ifdef LFSR_CHK_ZERO_DETECT_EN
    applyStimulus(mk("zdet", 0, 1, 4'b0000, 0, 0, 1, 1, 1, 1));
    applyStimulus(mk("zdet_clr", 0, 0, 4'b0000, 1, 0, 0, 0, 0, 1));
`else
    applyStimulus(mk("zlock", 0, 1, 4'b0000, 0, 1, 1, 1, 0, 1));
    applyStimulus(mk("zlock", 0, 1, 4'b1010, 0, 1, 0, 1, 0, 1));
    applyStimulus(mk("zlock_clr", 0, 0, 4'b0000, 1, 1, 0, 0, 0, 1));
`endif

    // Saturation on the 2-bit counter instance.
    applyStimulus(mk("satB", 1, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b0011, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b0111, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b1111, 0, 1, 0, 0, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b0001, 0, 1, 1, 1, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b0001, 0, 1, 1, 2, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b1010, 0, 1, 0, 2, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b0001, 0, 1, 1, 3, 0, 0));
    applyStimulus(mk("satB", 1, 1, 4'b0001, 0, 1, 1, 3, 0, 0));

    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
